// File: rtl/seg_pkg.sv
// seg_pkg: shared hex7 table, scan state encoding and display constants
package seg_pkg;
    localparam logic       ST_GUARD  = 1'b0;
    localparam logic       ST_SHOW   = 1'b1;
    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [3:0] AN_OFF    = 4'hF;

    typedef struct packed {
        logic [15:0] data;
        logic [3:0]  dp;
        logic [3:0]  blank;
    } disp_t;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'h3F;
            4'h1: hex7 = 7'h06;
            4'h2: hex7 = 7'h5B;
            4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66;
            4'h5: hex7 = 7'h6D;
            4'h6: hex7 = 7'h7D;
            4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F;
            4'h9: hex7 = 7'h6F;
            4'hA: hex7 = 7'h77;
            4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39;
            4'hD: hex7 = 7'h5E;
            4'hE: hex7 = 7'h79;
            default: hex7 = 7'h71;
        endcase
    endfunction
endpackage

// File: rtl/seg_hex7_dec.sv
// seg_hex7_dec: combinational hex nibble to active-high gfedcba segments
module seg_hex7_dec
    import seg_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [6:0] seg_o
);
    assign seg_o = hex7(nib_i);
endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: 4-digit multiplexed 7-segment scanner with guard blanking and tear-free updates
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int CLK_HZ  = 100000000,
    parameter int SCAN_HZ = 1000,
    parameter int GUARD   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] data,
    input  logic [3:0]  dp_mask,
    input  logic [3:0]  blank_mask,
    input  logic        load,
    output logic [3:0]  an,
    output logic [7:0]  seg_code,
    output logic        frame_done
);
    localparam int            DIV  = CLK_HZ / SCAN_HZ;
    localparam int            CW   = $clog2(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);
    localparam logic [CW-1:0] GRD  = CW'(GUARD);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    disp_t         pend_q, pend_d, act_q, act_d;
    logic          pv_q, pv_d;
    logic [3:0]    an_q, an_d;
    logic [7:0]    seg_q, seg_d;
    logic          fd_q;
    logic          tick, wrap, state, show;
    logic [3:0]    nib;
    logic [6:0]    hex;

    seg_hex7_dec u_dec (
        .nib_i (nib),
        .seg_o (hex)
    );

    // Next-state: prescaler, digit index, double-buffered registers and pin values
    always_comb begin
        tick   = cnt_q == LAST;
        wrap   = tick && idx_q == 2'd3;
        cnt_d  = tick ? '0 : cnt_q + 1'b1;
        idx_d  = tick ? idx_q + 2'd1 : idx_q;
        pend_d = load ? {data, dp_mask, blank_mask} : pend_q;
        pv_d   = load | (pv_q & ~wrap);
        act_d  = (wrap && pv_q) ? pend_q : act_q;
        state  = (cnt_q < GRD) ? ST_GUARD : ST_SHOW;
        nib    = act_q.data[{idx_q, 2'b00} +: 4];
        show   = state == ST_SHOW && !act_q.blank[idx_q];
        an_d   = show ? ~(4'b0001 << idx_q) : AN_OFF;
        seg_d  = show ? {~act_q.dp[idx_q], ~hex} : SEG_BLANK;
    end

    // State and registered pins; async reset blanks the display at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            idx_q  <= '0;
            pend_q <= '0;
            act_q  <= '0;
            pv_q   <= 1'b0;
            an_q   <= AN_OFF;
            seg_q  <= SEG_BLANK;
            fd_q   <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            pend_q <= pend_d;
            act_q  <= act_d;
            pv_q   <= pv_d;
            an_q   <= an_d;
            seg_q  <= seg_d;
            fd_q   <= wrap;
        end
    end

    assign an         = an_q;
    assign seg_code   = seg_q;
    assign frame_done = fd_q;
endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: table-driven and scoreboard checks of the scan driver
module tb_seg_scan_driver;
    import seg_pkg::*;

    typedef struct {
        logic [3:0] an;
        logic [7:0] seg;
    } exp_t;

    typedef struct packed {
        logic [15:0]     data;
        logic [3:0]      dp;
        logic [3:0]      bl;
        logic [3:0][3:0] an;
        logic [3:0][7:0] seg;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] data = '0;
    logic [3:0]  dp_mask = '0;
    logic [3:0]  blank_mask = '0;
    logic        load = 1'b0;
    logic [3:0]  an;
    logic [7:0]  seg_code;
    logic        frame_done;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    vec_t vecs[6];

    seg_scan_driver #(.CLK_HZ(16), .SCAN_HZ(1), .GUARD(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data       (data),
        .dp_mask    (dp_mask),
        .blank_mask (blank_mask),
        .load       (load),
        .an         (an),
        .seg_code   (seg_code),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global timeout");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic pulse_load(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] bl);
        data = d;
        dp_mask = dp;
        blank_mask = bl;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic push_frame(input logic [3:0][3:0] a, input logic [3:0][7:0] s);
        for (int i = 0; i < 4; i++) sb.push_back('{an: a[i], seg: s[i]});
    endtask

    task automatic sample(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty, got an=%h seg=%h", tag, an, seg_code);
        end else begin
            e = sb.pop_front();
            chk({tag, " an"}, 32'(an), 32'(e.an));
            chk({tag, " seg"}, 32'(seg_code), 32'(e.seg));
        end
    endtask

    task automatic wait_fd();
        bit seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            seen = frame_done;
        end
        chk("frame_done seen", 32'(seen), 32'd1);
    endtask

    task automatic show_frame(input string tag);
        repeat (9) @(negedge clk);
        sample({tag, " d0"});
        for (int d = 1; d < 4; d++) begin
            repeat (16) @(negedge clk);
            sample($sformatf("%s d%0d", tag, d));
        end
    endtask

    task automatic release_check(input string tag);
        rst_n = 1'b1;
        chk({tag, " c0 an"}, 32'(an), 32'hF);
        chk({tag, " c0 seg"}, 32'(seg_code), 32'hFF);
        for (int c = 1; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("%s c%0d an", tag, c), 32'(an), 32'hF);
            chk($sformatf("%s c%0d seg", tag, c), 32'(seg_code), 32'hFF);
        end
        @(negedge clk);
        chk({tag, " c3 an"}, 32'(an), 32'hE);
        chk({tag, " c3 seg"}, 32'(seg_code), 32'hC0);
    endtask

    initial begin
        vecs[0] = '{16'h1234, 4'h0, 4'h0, {4'h7, 4'hB, 4'hD, 4'hE}, {8'hF9, 8'hA4, 8'hB0, 8'h99}};
        vecs[1] = '{16'hFFFF, 4'h0, 4'h0, {4'h7, 4'hB, 4'hD, 4'hE}, {8'h8E, 8'h8E, 8'h8E, 8'h8E}};
        vecs[2] = '{16'h5678, 4'h4, 4'h8, {4'hF, 4'hB, 4'hD, 4'hE}, {8'hFF, 8'h02, 8'hF8, 8'h80}};
        vecs[3] = '{16'h9ABC, 4'hF, 4'h0, {4'h7, 4'hB, 4'hD, 4'hE}, {8'h10, 8'h08, 8'h03, 8'h46}};
        vecs[4] = '{16'hDE0F, 4'h2, 4'h5, {4'h7, 4'hF, 4'hD, 4'hF}, {8'hA1, 8'hFF, 8'h40, 8'hFF}};
        vecs[5] = '{16'h0000, 4'h0, 4'hF, {4'hF, 4'hF, 4'hF, 4'hF}, {8'hFF, 8'hFF, 8'hFF, 8'hFF}};

        repeat (3) @(negedge clk);
        chk("reset an", 32'(an), 32'hF);
        chk("reset seg", 32'(seg_code), 32'hFF);
        chk("reset frame_done", 32'(frame_done), 32'd0);
        release_check("release");

        for (int v = 0; v < 6; v++) begin
            pulse_load(vecs[v].data, vecs[v].dp, vecs[v].bl);
            push_frame(vecs[v].an, vecs[v].seg);
            wait_fd();
            show_frame($sformatf("vec%0d", v));
        end

        pulse_load(16'h1234, 4'h0, 4'h0);
        wait_fd();
        push_frame({4'h7, 4'hB, 4'hD, 4'hE}, {8'hF9, 8'hA4, 8'hB0, 8'h99});
        repeat (9) @(negedge clk);
        sample("tear d0");
        repeat (11) @(negedge clk);
        pulse_load(16'hFFFF, 4'h0, 4'h0);
        repeat (4) @(negedge clk);
        sample("tear d1");
        repeat (16) @(negedge clk);
        sample("tear d2");
        repeat (16) @(negedge clk);
        sample("tear d3");
        push_frame({4'h7, 4'hB, 4'hD, 4'hE}, {8'h8E, 8'h8E, 8'h8E, 8'h8E});
        wait_fd();
        show_frame("tear new");

        wait_fd();
        pulse_load(16'hC0DE, 4'h0, 4'h0);
        repeat (62) @(negedge clk);
        pulse_load(16'h8421, 4'h0, 4'h0);
        chk("coinc frame_done", 32'(frame_done), 32'd1);
        chk("coinc active", 32'(dut.act_q), 32'({16'hC0DE, 8'h00}));
        chk("coinc pending", 32'(dut.pend_q), 32'({16'h8421, 8'h00}));
        chk("coinc pv", 32'(dut.pv_q), 32'd1);
        push_frame({4'h7, 4'hB, 4'hD, 4'hE}, {8'hC6, 8'hC0, 8'hA1, 8'h86});
        show_frame("coinc old");
        push_frame({4'h7, 4'hB, 4'hD, 4'hE}, {8'h80, 8'h99, 8'hA4, 8'hF9});
        wait_fd();
        show_frame("coinc new");

        pulse_load(16'h5555, 4'h0, 4'h0);
        chk("pre-reset an", 32'(an), 32'h7);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async reset an", 32'(an), 32'hF);
        chk("async reset seg", 32'(seg_code), 32'hFF);
        chk("async reset pv", 32'(dut.pv_q), 32'd0);
        @(negedge clk);
        release_check("re-release");
        chk("post-reset pv", 32'(dut.pv_q), 32'd0);
        push_frame({4'h7, 4'hB, 4'hD, 4'hE}, {8'hC0, 8'hC0, 8'hC0, 8'hC0});
        wait_fd();
        show_frame("discard");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
